// File: rtl/display_pkg.sv
// Shared display constants, pixel formats and the fetch FSM state type
// for the LCD pixel-data path.
`timescale 1ns/1ps
package display_pkg;

  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 272;
  localparam int H_TOTAL  = 525;
  localparam int V_TOTAL  = 351;
  localparam int ADDR_W   = 17;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {PRIME, IDLE, FETCH} fetch_state_t;

  // MSB replication keeps full-scale 565 values at full-scale 888.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t o;
    o.r = {p.r, p.r[4:2]};
    o.g = {p.g, p.g[5:4]};
    o.b = {p.b, p.b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Ping-pong line store: two banks of one active line of RGB565,
// one write port and one registered read port.
`timescale 1ns/1ps
module line_buffer_2bank
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        wr_bank,
  input  logic [8:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        rd_bank,
  input  logic [8:0]  rd_addr,
  output logic [15:0] rd_data
);

  logic [15:0] mem [2][H_ACTIVE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/lcd_line_fetcher.sv
// Prefetches the next active line from frame memory into a ping-pong buffer
// and drives registered RGB888 in step with DrawX/DrawY.
// Optional colour-bar generator enabled by defining DISP_TEST_PATTERN_EN.
//
//  state | meaning
//  PRIME | after reset: fetch line 0 into bank 1
//  IDLE  | next line buffered, waiting for the line-start trigger
//  FETCH | streaming the target line into the write bank
`timescale 1ns/1ps
module lcd_line_fetcher
  import display_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
`ifdef DISP_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              underrun
);

  localparam logic [8:0] LAST_X = 9'(H_ACTIVE - 1);

  logic [1:0]   pix_sync_q;
  logic         pix_stb;
  logic         trig;
  logic [8:0]   trig_line;
  fetch_state_t state_q, state_d;
  logic [8:0]   line_q, line_d, x_q, x_d, pend_line_q, pend_line_d;
  logic         rd_bank_q, rd_bank_d, ready_q, ready_d, bad_q, bad_d;
  logic         pend_q, pend_d, underrun_d, wr_en;
  logic [15:0]  rd_data;
  logic         s1_vld, s1_vis, s1_bad;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pix_sync_q <= '0;
    else       pix_sync_q <= {pix_sync_q[0], pixel_clk};
  end
  assign pix_stb = pix_sync_q[1] & ~pix_sync_q[0];

  always_comb begin
    trig      = 1'b0;
    trig_line = '0;
    if (pix_stb && DrawX == 10'd0) begin
      if (DrawY < 10'(V_ACTIVE - 1)) begin
        trig      = 1'b1;
        trig_line = 9'(DrawY + 10'd1);
      end else if (DrawY == 10'(V_TOTAL - 1)) begin
        trig = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= PRIME;
      line_q      <= '0;
      x_q         <= '0;
      rd_bank_q   <= 1'b0;
      ready_q     <= 1'b0;
      bad_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_line_q <= '0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      x_q         <= x_d;
      rd_bank_q   <= rd_bank_d;
      ready_q     <= ready_d;
      bad_q       <= bad_d;
      pend_q      <= pend_d;
      pend_line_q <= pend_line_d;
      underrun    <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    x_d         = x_q;
    rd_bank_d   = rd_bank_q;
    ready_d     = ready_q;
    bad_d       = bad_q;
    pend_d      = pend_q;
    pend_line_d = pend_line_q;
    underrun_d  = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      PRIME: begin
        if (mem_ack) begin
          wr_en = 1'b1;
          if (x_q == LAST_X) begin
            x_d     = '0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
        if (trig) begin
          underrun_d = 1'b1;
          bad_d      = 1'b1;
        end
      end
      IDLE: begin
        if (trig) begin
          if (ready_q) begin
            rd_bank_d = ~rd_bank_q;
            ready_d   = 1'b0;
            bad_d     = 1'b0;
            line_d    = trig_line;
            x_d       = '0;
            state_d   = FETCH;
          end else begin
            underrun_d = 1'b1;
            bad_d      = 1'b1;
          end
        end
      end
      FETCH: begin
        // An outstanding request must see its ack before the restart.
        if (mem_ack) begin
          wr_en = 1'b1;
          if (trig || pend_q) begin
            line_d = trig ? trig_line : pend_line_q;
            x_d    = '0;
            pend_d = 1'b0;
          end else if (x_q == LAST_X) begin
            ready_d = 1'b1;
            x_d     = '0;
            state_d = IDLE;
          end else begin
            x_d = x_q + 9'd1;
          end
        end else if (trig) begin
          pend_d      = 1'b1;
          pend_line_d = trig_line;
        end
        if (trig) begin
          underrun_d = 1'b1;
          bad_d      = 1'b1;
        end
      end
      default: state_d = PRIME;
    endcase
  end

  assign mem_req  = !Reset && (state_q != IDLE);
  assign mem_addr = (ADDR_W'(line_q) << 9) - (ADDR_W'(line_q) << 5) + ADDR_W'(x_q);

  // Read with the post-trigger bank so pixel 0 already shows the new line.
  line_buffer_2bank u_buf (
    .clk     (Clk),
    .wr_bank (~rd_bank_q),
    .wr_addr (x_q),
    .wr_data (mem_rdata),
    .wr_en   (wr_en),
    .rd_en   (pix_stb),
    .rd_bank (rd_bank_d),
    .rd_addr (DrawX[8:0]),
    .rd_data (rd_data)
  );

`ifdef DISP_TEST_PATTERN_EN
  logic       s1_test;
  logic [2:0] s1_bar;
  rgb888_t    bar_rgb;

  always_comb begin
    bar_rgb = '0;
    case (s1_bar)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_test <= 1'b0;
      s1_bar  <= '0;
    end else if (pix_stb) begin
      s1_test <= test_mode;
      s1_bar  <= 3'(DrawX / 10'd60);
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_vld <= 1'b0;
      s1_vis <= 1'b0;
      s1_bad <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      s1_vld <= pix_stb;
      if (pix_stb) begin
        s1_vis <= blank;
        s1_bad <= bad_d;
      end
      if (s1_vld) begin
        if (!s1_vis)
          {red, green, blue} <= '0;
`ifdef DISP_TEST_PATTERN_EN
        else if (s1_test)
          {red, green, blue} <= bar_rgb;
`endif
        else if (s1_bad)
          {red, green, blue} <= '0;
        else
          {red, green, blue} <= rgb565_to_888(rd_data);
      end
    end
  end

endmodule

// File: tb/tb_lcd_line_fetcher.sv
// Directed bench for lcd_line_fetcher with a req/ack frame-memory model
// that returns addr[15:0] after a programmable number of wait cycles.
`timescale 1ns/1ps
module tb_lcd_line_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_clk = 1'b1;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;
  logic        blank = 1'b0;
  logic        mem_req, mem_ack, underrun;
  logic [16:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [7:0]  red, green, blue;
`ifdef DISP_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int ur_cnt = 0;
  int ack_delay = 1;
  int wcnt = 0;

  always #10 clk = ~clk;

  lcd_line_fetcher dut (
    .Clk       (clk),
    .Reset     (reset),
    .pixel_clk (pixel_clk),
    .DrawX     (draw_x),
    .DrawY     (draw_y),
    .blank     (blank),
`ifdef DISP_TEST_PATTERN_EN
    .test_mode (test_mode),
`endif
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .underrun  (underrun)
  );

  assign mem_ack   = mem_req && (wcnt >= ack_delay);
  assign mem_rdata = mem_addr[15:0];

  always @(posedge clk) begin
    wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
    if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
  end

  typedef struct {
    int          y;
    int          x;
    logic        vis;
    logic [23:0] rgb;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rgb(input string name, input logic [23:0] exp);
    chk(name, {8'h00, red, green, blue}, {8'h00, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the Clk edge at which the strobe is acted on;
  // RGB updates on the following edge.
  task automatic strobe(input int x, input int y, input logic vis);
    @(negedge clk);
    pixel_clk = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    draw_x    = 10'(x);
    draw_y    = 10'(y);
    blank     = vis;
    pixel_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input string name);
    for (int i = 0; i < 12000 && mem_req; i++) step(1);
    chk(name, {31'd0, mem_req}, 32'd0);
  endtask

  task automatic poll_addr(input string name, input int exp);
    for (int i = 0; i < 40 && mem_addr != 17'(exp); i++) step(1);
    chk(name, {15'd0, mem_addr}, 32'(exp));
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,   0,   1'b1, 24'h000000};
    vecs[1]  = '{0,   5,   1'b1, 24'h000029};
    vecs[2]  = '{0,   479, 1'b1, 24'h0038FF};
    vecs[3]  = '{0,   480, 1'b0, 24'h000000};
    vecs[4]  = '{1,   0,   1'b1, 24'h003C00};
    vecs[5]  = '{1,   200, 1'b1, 24'h005542};
    vecs[6]  = '{1,   100, 1'b0, 24'h000000};
    vecs[7]  = '{2,   0,   1'b1, 24'h007900};
    vecs[8]  = '{2,   479, 1'b1, 24'h00B2FF};
    vecs[9]  = '{268, 0,   1'b1, 24'h00B600};
    vecs[10] = '{269, 0,   1'b1, 24'hFF0C00};
    vecs[11] = '{270, 0,   1'b1, 24'hFF4900};
    vecs[12] = '{270, 5,   1'b1, 24'hFF4929};

    // Reset state and priming of line 0 (ack one cycle after request)
    step(3);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {15'd0, mem_addr}, 32'd0);
    chk_rgb("rst_rgb", 24'h000000);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("prime_req", {31'd0, mem_req}, 32'd1);
    chk("prime_addr", {15'd0, mem_addr}, 32'd0);
    wait_fetch("prime_done");

    strobe(0, 0, 1'b1);
    step(1);
    chk_rgb("t1_x0", 24'h000000);
    strobe(5, 0, 1'b1);
    chk_rgb("t1_x5_not_early", 24'h000000);
    step(1);
    chk_rgb("t1_x5_latency2", 24'h000029);

    // Reset in the middle of the line-1 fetch
    chk("t5_req_before", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_req_dropped", {31'd0, mem_req}, 32'd0);
    chk_rgb("t5_rgb_cleared", 24'h000000);
    chk("t5_underrun", {31'd0, underrun}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_reprime_req", {31'd0, mem_req}, 32'd1);
    chk("t5_reprime_addr", {15'd0, mem_addr}, 32'd0);
    ack_delay = 0;
    wait_fetch("t5_reprime_done");

    // Zero-wait memory: table of visible/blank pixels across several lines
    for (int i = 0; i < 13; i++) begin
      strobe(vecs[i].x, vecs[i].y, vecs[i].vis);
      step(1);
      if (vecs[i].x == 0) wait_fetch($sformatf("vec%0d_fetch", i));
      chk_rgb($sformatf("vec%0d_rgb", i), vecs[i].rgb);
    end
    chk("t2_no_underrun", 32'(ur_cnt), 32'd0);

    // Last active line triggers nothing; last total line fetches line 0
    strobe(0, 271, 1'b1);
    chk("t4_271_no_req", {31'd0, mem_req}, 32'd0);
    step(5);
    chk("t4_271_still_idle", {31'd0, mem_req}, 32'd0);
    strobe(0, 350, 1'b0);
    chk("t4_350_req", {31'd0, mem_req}, 32'd1);
    chk("t4_350_addr0", {15'd0, mem_addr}, 32'd0);
    wait_fetch("t4_350_fetch");
    strobe(0, 0, 1'b1);
    step(1);
    wait_fetch("t4_line1_fetch");
    strobe(3, 0, 1'b1);
    step(1);
    chk_rgb("t4_line0_x3", 24'h000018);
    chk("t4_no_underrun", 32'(ur_cnt), 32'd0);

    // Slow memory: each following trigger underruns and restarts the fetch
    ack_delay = 10;
    strobe(0, 1, 1'b1);
    step(1);
    chk_rgb("t3_line1_x0", 24'h003C00);
    strobe(200, 1, 1'b1);
    step(1);
    chk_rgb("t3_line1_x200", 24'h005542);
    chk("t3_no_underrun_yet", 32'(ur_cnt), 32'd0);
    step(100);
    strobe(0, 2, 1'b1);
    step(1);
    chk_rgb("t3_line2_bad_x0", 24'h000000);
    chk("t3_underrun_1", 32'(ur_cnt), 32'd1);
    poll_addr("t3_restart_line3", 3 * 480);
    strobe(5, 2, 1'b1);
    step(1);
    chk_rgb("t3_line2_bad_x5", 24'h000000);
    step(100);
    strobe(0, 3, 1'b1);
    step(1);
    chk("t3_underrun_2", 32'(ur_cnt), 32'd2);
    poll_addr("t3_restart_line4", 4 * 480);
    strobe(200, 3, 1'b1);
    step(1);
    chk_rgb("t3_line3_bad_x200", 24'h000000);
    chk("t3_req_held", {31'd0, mem_req}, 32'd1);

`ifdef DISP_TEST_PATTERN_EN
    test_mode = 1'b1;
    strobe(0, 4, 1'b1);
    step(1);
    chk_rgb("t6_bar_x0", 24'hFFFFFF);
    strobe(125, 4, 1'b1);
    step(1);
    chk_rgb("t6_bar_x125", 24'h00FFFF);
    strobe(479, 4, 1'b1);
    step(1);
    chk_rgb("t6_bar_x479", 24'h000000);
    strobe(10, 4, 1'b0);
    step(1);
    chk_rgb("t6_blank", 24'h000000);
    test_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
